stencil_edge_pad_source: RTL and testbench
==========================================

Name: stencil_edge_pad_source

Overview:
- Transmit-side companion of the stencil line buffer: produces the pixel stream that feeds the 4-tap blur line buffer.
- Accepts raw row pixels over a ready/valid handshake.
- Emits each row with replicate-edge (clamp) padding, so the downstream FIR produces full-width output without garbage warm-up taps.
- Sits between the input DMA/stream and the line buffer input port; carries row/frame framing flags.

Parameters:
- WIDTH, 16, pixel bit width (raw bits; signedness irrelevant, values passed unmodified).
- ROW_LEN, 64, input pixels per row; legal 2..4096.
- NUM_ROWS, 64, rows per frame; legal 1..4096.
- PAD_L, 2, replicated copies of the first pixel emitted before it; legal 0..7.
- PAD_R, 1, replicated copies of the last pixel emitted after it; legal 0..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  upstream pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  padded pixel stream.
- out_first  out  1  first beat of a row.
- out_last  out  1  final beat of a row.
- out_eof  out  1  final beat of the final row of a frame.

Behaviour:
- Reset: all outputs 0; state IDLE; col_cnt, row_cnt, pad_cnt 0; hold registers 0.
- Output is a single registered slot. slot_free = !out_valid || out_ready. A beat transfers when out_valid && out_ready. Loading the slot sets out_valid=1. If slot_free and nothing is loaded, out_valid goes to 0.
- in_ready = slot_free && state in {IDLE, BODY}. It is combinational from out_ready; no combinational path from in_valid.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 beat/cycle under continuous ready. Each row is ROW_LEN+PAD_L+PAD_R output beats. Rows run back-to-back with no bubble.
- IDLE:
  - On accept of p0: load slot with p0 and out_first=1; store p0 in edge_reg.
  - If PAD_L>0: go to LEFT with pad_cnt=PAD_L.
  - Otherwise: go to BODY with col_cnt=1.
  - Special case ROW_LEN reached (col_cnt would equal ROW_LEN): treat as last pixel per the BODY rule.
- LEFT:
  - in_ready=0. When slot_free: load edge_reg (out_first=0) and decrement pad_cnt.
  - When pad_cnt reaches 0 after the load: go to BODY with col_cnt=1.
- BODY:
  - On accept: load pixel and increment col_cnt.
  - When the accepted pixel is index ROW_LEN-1: store it in edge_reg.
    - If PAD_R>0: go to RIGHT with pad_cnt=PAD_R.
    - Otherwise: set out_last on this beat and end the row.
- RIGHT:
  - in_ready=0. When slot_free: load edge_reg and decrement pad_cnt.
  - The load with pad_cnt==1 sets out_last and ends the row.
- Row end:
  - State goes to IDLE.
  - If row_cnt==NUM_ROWS-1: out_eof=1 on the same beat as out_last, and row_cnt wraps to 0. Otherwise row_cnt increments.
- Flags:
  - out_first, out_last and out_eof are loaded with the data and held with it.
  - All flags are stable while out_valid && !out_ready (standard no-change-under-stall rule).
- Backpressure:
  - out_data and the flags hold while stalled; no beat is dropped or duplicated.
  - Padding beats are not generated while stalled.
- Reset mid-row: asynchronous clear of everything. The next accepted pixel starts a new row with out_first and row_cnt=0.
- No combinational loop: out_ready does not depend on this block.

Decomposition:
- Shared package stencil_stream_pkg:
  - state enum {IDLE, LEFT, BODY, RIGHT}.
  - Default pixel WIDTH constant.
  - Counter width function (clog2 of ROW_LEN / NUM_ROWS).
- One natural sub-module: stencil_out_slot. It is the registered output slot holding data plus first/last/eof and valid, and exports slot_free.
- The FSM and counters live in the top.

Test Plan:
- ROW_LEN=4, PAD_L=2, PAD_R=1, NUM_ROWS=2, continuous ready.
  - Stimulus: row 10,20,30,40.
  - Required: out 10,10,10,20,30,40,40; first on beat0 only, last on beat6, eof=0.
- Same config, two rows 10,20,30,40 then 1,2,3,4 with continuous valid/ready.
  - Required: 14 beats in 14 consecutive cycles after the first out_valid.
  - eof only on beat13 (value 4); row_cnt wraps so a third row has eof=0 on its last beat.
- Backpressure: out_ready=0 for 3 cycles while beat1 (10) is presented.
  - Required: out_data=10 and out_first=0 held, in_ready=0, sequence otherwise identical to scenario 1.
- Reset asserted asynchronously after 3 output beats of a row.
  - Required: outputs 0 immediately.
  - After release, row 7,8,9,6 yields 7,7,7,8,9,6,6 with first on 7.
- PAD_L=0, PAD_R=0, ROW_LEN=3, row 0xFFFB,0x0001,0x8000.
  - Required: out exactly 0xFFFB,0x0001,0x8000; first and last on beats 0 and 2; no extra beats.
- Upstream gaps: in_valid toggles 1,0,1,0 in BODY.
  - Required: out_valid bubbles match the gaps; no duplicate pixels; in_ready=0 throughout LEFT/RIGHT regardless of in_valid.

Source files
------------

// File: rtl/stencil_stream_pkg.sv
// Shared definitions for the stencil stream blocks: FSM state encoding,
// default pixel width and counter sizing helper.
package stencil_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    BODY,
    RIGHT
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Pad counts are limited to 0..7.
  localparam int PAD_CNT_W = 3;

  // Bits needed to hold a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stencil_out_slot.sv
// Single registered output slot: holds one beat (data plus row/frame flags)
// and exports slot_free so the producer knows it may load this cycle.
module stencil_out_slot
  import stencil_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_first,
  input  logic             i_last,
  input  logic             i_eof,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_first,
  output logic             o_last,
  output logic             o_eof,
  output logic             o_slot_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_first;
  logic             r_last;
  logic             r_eof;

  // The slot can take a new beat when it is empty or its beat leaves now.
  assign o_slot_free = !r_valid || i_out_ready;

  // Load a new beat, drain to empty, or hold everything while stalled.
  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_first <= i_first;
      r_last  <= i_last;
      r_eof   <= i_eof;
    end else if (o_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_first = r_first;
  assign o_last  = r_last;
  assign o_eof   = r_eof;

endmodule

// File: rtl/stencil_edge_pad_source.sv
// Replicate-edge padding source: takes raw row pixels and emits each row
// with PAD_L copies of the first pixel before it and PAD_R copies of the
// last pixel after it, tagging first/last/eof beats for the line buffer.
module stencil_edge_pad_source
  import stencil_stream_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int ROW_LEN  = 64,
  parameter int NUM_ROWS = 64,
  parameter int PAD_L    = 2,
  parameter int PAD_R    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_eof
);

  localparam int COL_W = cnt_width(ROW_LEN);
  localparam int ROW_W = cnt_width(NUM_ROWS);

  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [PAD_CNT_W-1:0] PAD_L_CNT = PAD_CNT_W'(PAD_L);
  localparam logic [PAD_CNT_W-1:0] PAD_R_CNT = PAD_CNT_W'(PAD_R);

  state_e                 r_state;
  logic [COL_W-1:0]       r_col_cnt;
  logic [ROW_W-1:0]       r_row_cnt;
  logic [PAD_CNT_W-1:0]   r_pad_cnt;
  logic [WIDTH-1:0]       r_edge;

  logic                   w_slot_free;
  logic                   w_accept;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_pad_last;
  logic [ROW_W-1:0]       w_row_next;

  logic                   w_load;
  logic [WIDTH-1:0]       w_load_data;
  logic                   w_load_first;
  logic                   w_load_last;
  logic                   w_load_eof;

  // Upstream is only accepted while pixels are being passed through; pad
  // beats come from r_edge, so in_ready never depends on in_valid.
  assign in_ready   = w_slot_free && ((r_state == IDLE) || (r_state == BODY));
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col_cnt == COL_LAST);
  assign w_row_last = (r_row_cnt == ROW_LAST);
  assign w_pad_last = (r_pad_cnt == PAD_CNT_W'(1));
  assign w_row_next = w_row_last ? '0 : r_row_cnt + ROW_W'(1);

  // Decide what (if anything) goes into the output slot this cycle.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default in always_comb would infer a latch.
  always_comb begin
    w_load       = 1'b0;
    w_load_data  = in_data;
    w_load_first = 1'b0;
    w_load_last  = 1'b0;
    w_load_eof   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_load_first = 1'b1;
        end
      end
      LEFT: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_edge;
        end
      end
      BODY: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_col_last && (PAD_R == 0)) begin
            w_load_last = 1'b1;
            w_load_eof  = w_row_last;
          end
        end
      end
      RIGHT: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_edge;
          if (w_pad_last) begin
            w_load_last = 1'b1;
            w_load_eof  = w_row_last;
          end
        end
      end
      default: ;
    endcase
  end

  // Row sequencing FSM with column, row and pad counters and the edge pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_pad_cnt <= '0;
      r_edge    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_edge <= in_data;
            if (PAD_L > 0) begin
              r_state   <= LEFT;
              r_pad_cnt <= PAD_L_CNT;
            end else begin
              r_state   <= BODY;
              r_col_cnt <= COL_W'(1);
            end
          end
        end
        LEFT: begin
          if (w_slot_free) begin
            r_pad_cnt <= r_pad_cnt - PAD_CNT_W'(1);
            if (w_pad_last) begin
              r_state   <= BODY;
              r_col_cnt <= COL_W'(1);
            end
          end
        end
        BODY: begin
          if (w_accept) begin
            r_col_cnt <= r_col_cnt + COL_W'(1);
            if (w_col_last) begin
              r_edge <= in_data;
              if (PAD_R > 0) begin
                r_state   <= RIGHT;
                r_pad_cnt <= PAD_R_CNT;
              end else begin
                r_state   <= IDLE;
                r_col_cnt <= '0;
                r_row_cnt <= w_row_next;
              end
            end
          end
        end
        RIGHT: begin
          if (w_slot_free) begin
            r_pad_cnt <= r_pad_cnt - PAD_CNT_W'(1);
            if (w_pad_last) begin
              r_state   <= IDLE;
              r_col_cnt <= '0;
              r_row_cnt <= w_row_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stencil_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .i_first     (w_load_first),
    .i_last      (w_load_last),
    .i_eof       (w_load_eof),
    .i_out_ready (out_ready),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_first     (out_first),
    .o_last      (out_last),
    .o_eof       (out_eof),
    .o_slot_free (w_slot_free)
  );

endmodule

// File: tb/tb_stencil_edge_pad_source.sv
// Directed bench for stencil_edge_pad_source. Instance A: ROW_LEN=4,
// PAD_L=2, PAD_R=1, NUM_ROWS=2. Instance B: ROW_LEN=3, no padding,
// NUM_ROWS=1. Both share the input stimulus; use_b selects which is observed.
module tb_stencil_edge_pad_source;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
    logic        eof;
    int          cyc;
  } beat_t;

  typedef struct {
    logic        v;
    logic        r;
    logic        rdy;
    logic        ovalid;
    logic [15:0] odata;
    logic        ofirst;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        use_b = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_first, a_out_last, a_out_eof;
  logic [15:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_first, b_out_last, b_out_eof;
  logic [15:0] b_out_data;

  logic        obs_in_ready, obs_out_valid, obs_out_first, obs_out_last, obs_out_eof;
  logic [15:0] obs_out_data;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  cyc_t        log_q[$];
  logic [15:0] stim[$];
  int          idx;
  int          g_cyc;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  stencil_edge_pad_source #(
    .WIDTH(16), .ROW_LEN(4), .NUM_ROWS(2), .PAD_L(2), .PAD_R(1)
  ) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_first(a_out_first), .out_last(a_out_last), .out_eof(a_out_eof)
  );

  stencil_edge_pad_source #(
    .WIDTH(16), .ROW_LEN(3), .NUM_ROWS(1), .PAD_L(0), .PAD_R(0)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_first(b_out_first), .out_last(b_out_last), .out_eof(b_out_eof)
  );

  assign obs_in_ready  = use_b ? b_in_ready  : a_in_ready;
  assign obs_out_valid = use_b ? b_out_valid : a_out_valid;
  assign obs_out_data  = use_b ? b_out_data  : a_out_data;
  assign obs_out_first = use_b ? b_out_first : a_out_first;
  assign obs_out_last  = use_b ? b_out_last  : a_out_last;
  assign obs_out_eof   = use_b ? b_out_eof   : a_out_eof;

  // Called at posedge+1; drives one cycle, samples at negedge, returns at next posedge+1.
  task automatic step(input logic v, input logic r);
    cyc_t  c;
    beat_t b;
    in_valid  = v;
    in_data   = 16'h0;
    if (v) in_data = stim[idx];
    out_ready = r;
    @(negedge clk);
    c.v = v; c.r = r; c.rdy = obs_in_ready; c.ovalid = obs_out_valid;
    c.odata = obs_out_data; c.ofirst = obs_out_first;
    log_q.push_back(c);
    if (obs_out_valid && r) begin
      b.data = obs_out_data; b.first = obs_out_first; b.last = obs_out_last;
      b.eof = obs_out_eof; b.cyc = g_cyc;
      got_q.push_back(b);
    end
    if (v && obs_in_ready) idx++;
    g_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Feed stim until `target` beats are collected or max_cyc expires.
  task automatic run(input int target, input bit gap, input int stall_beat,
                     input int stall_len, input int max_cyc);
    int   stall_left;
    logic v, r;
    stall_left = stall_len;
    for (int c = 0; c < max_cyc && got_q.size() < target; c++) begin
      v = (idx < stim.size()) && (!gap || (c % 2 == 0));
      r = 1'b1;
      if (stall_left > 0 && got_q.size() == stall_beat && obs_out_valid) begin
        r = 1'b0;
        stall_left--;
      end
      step(v, r);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    log_q.delete();
    idx   = 0;
    g_cyc = 0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  // Reference padding model built from the row pixels in stim.
  task automatic build_exp(input int padl, input int padr, input int rowlen, input int nrows);
    int    total, src, nr;
    beat_t b;
    exp_q.delete();
    total = padl + rowlen + padr;
    nr    = stim.size() / rowlen;
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < total; k++) begin
        if (k <= padl) src = 0;
        else if (k - padl < rowlen) src = k - padl;
        else src = rowlen - 1;
        b.data  = stim[r * rowlen + src];
        b.first = (k == 0);
        b.last  = (k == total - 1);
        b.eof   = (k == total - 1) && (r % nrows == nrows - 1);
        b.cyc   = 0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    n_total++;
    if ({a_out_valid, a_out_data, a_out_first, a_out_last, a_out_eof} !== 20'h0) begin
      $display("FAIL reset_outputs got v=%b d=%h f=%b l=%b e=%b want all 0",
               a_out_valid, a_out_data, a_out_first, a_out_last, a_out_eof);
    end else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_total++;
    if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_row();
    logic exp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    use_b = 1'b0;
    do_reset();
    stim = '{16'd10, 16'd20, 16'd30, 16'd40};
    run(7, 1'b0, -1, 0, 40);
    build_exp(2, 1, 4, 2);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof})
        $display("FAIL single_beat%0d got %h f%b l%b e%b want %h f%b l%b e%b", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof);
      else n_pass++;
    end
    for (int c = 0; c < 7 && c < log_q.size(); c++) begin
      n_total++;
      if (log_q[c].rdy !== exp_rdy[c]) $display("FAIL single_in_ready_c%0d got %b want %b", c, log_q[c].rdy, exp_rdy[c]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    use_b = 1'b0;
    do_reset();
    stim = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd1, 16'd2, 16'd3, 16'd4,
             16'd5, 16'd6, 16'd7, 16'd8};
    run(21, 1'b0, -1, 0, 80);
    build_exp(2, 1, 4, 2);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof})
        $display("FAIL b2b_beat%0d got %h f%b l%b e%b want %h f%b l%b e%b", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (got_q[i].cyc != got_q[0].cyc + i)
          $display("FAIL b2b_cycle%0d got %0d want %0d", i, got_q[i].cyc, got_q[0].cyc + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    use_b = 1'b0;
    do_reset();
    stim = '{16'd10, 16'd20, 16'd30, 16'd40};
    run(7, 1'b0, 1, 3, 40);
    build_exp(2, 1, 4, 2);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof})
        $display("FAIL bp_beat%0d got %h f%b l%b e%b want %h f%b l%b e%b", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof);
      else n_pass++;
    end
    stalls = 0;
    for (int c = 0; c < log_q.size(); c++) begin
      if (!log_q[c].r) begin
        stalls++;
        n_total++;
        if ({log_q[c].ovalid, log_q[c].odata, log_q[c].ofirst, log_q[c].rdy} !== {1'b1, 16'd10, 1'b0, 1'b0})
          $display("FAIL bp_hold_c%0d got v%b d%h f%b rdy%b want v1 d000a f0 rdy0", c,
                   log_q[c].ovalid, log_q[c].odata, log_q[c].ofirst, log_q[c].rdy);
        else n_pass++;
      end
    end
    n_total++;
    if (stalls != 3) $display("FAIL bp_stall_cycles got %0d want 3", stalls);
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    use_b = 1'b0;
    do_reset();
    stim = '{16'd10, 16'd20, 16'd30, 16'd40};
    run(3, 1'b0, -1, 0, 20);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({a_out_valid, a_out_data, a_out_first, a_out_last, a_out_eof} !== 20'h0)
      $display("FAIL midrst_outputs got v=%b d=%h f=%b l=%b e=%b want all 0",
               a_out_valid, a_out_data, a_out_first, a_out_last, a_out_eof);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    stim = '{16'd7, 16'd8, 16'd9, 16'd6};
    run(7, 1'b0, -1, 0, 40);
    build_exp(2, 1, 4, 2);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof})
        $display("FAIL midrst_beat%0d got %h f%b l%b e%b want %h f%b l%b e%b", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof);
      else n_pass++;
    end
  endtask

  task automatic test_no_pad();
    use_b = 1'b1;
    do_reset();
    stim = '{16'hFFFB, 16'h0001, 16'h8000};
    run(3, 1'b0, -1, 0, 20);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    build_exp(0, 0, 3, 1);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL nopad_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof})
        $display("FAIL nopad_beat%0d got %h f%b l%b e%b want %h f%b l%b e%b", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof);
      else n_pass++;
    end
    use_b = 1'b0;
  endtask

  task automatic test_gaps();
    int exp_cyc [7] = '{1, 2, 3, 5, 7, 9, 10};
    int rdy0_c  [3] = '{1, 2, 9};
    int bub_c   [3] = '{4, 6, 8};
    use_b = 1'b0;
    do_reset();
    stim = '{16'd10, 16'd20, 16'd30, 16'd40};
    run(7, 1'b1, -1, 0, 40);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1);
    build_exp(2, 1, 4, 2);
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL gap_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_total++;
      if ({got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof, got_q[i].cyc} !==
          {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof, exp_cyc[i]})
        $display("FAIL gap_beat%0d got %h f%b l%b e%b @%0d want %h f%b l%b e%b @%0d", i,
                 got_q[i].data, got_q[i].first, got_q[i].last, got_q[i].eof, got_q[i].cyc,
                 exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].eof, exp_cyc[i]);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rdy0_c[k] >= log_q.size() || log_q[rdy0_c[k]].rdy !== 1'b0)
        $display("FAIL gap_pad_in_ready_c%0d got %b want 0", rdy0_c[k],
                 (rdy0_c[k] < log_q.size()) ? log_q[rdy0_c[k]].rdy : 1'bx);
      else n_pass++;
      n_total++;
      if (bub_c[k] >= log_q.size() || log_q[bub_c[k]].ovalid !== 1'b0)
        $display("FAIL gap_bubble_c%0d got %b want 0", bub_c[k],
                 (bub_c[k] < log_q.size()) ? log_q[bub_c[k]].ovalid : 1'bx);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_row();
    test_no_pad();
    test_gaps();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
